// File: rtl/stopwatch_lap_controller.sv
// Stopwatch sequencing controller.
// Conditions three raw push-buttons (synchronise, debounce, rising-edge pulse), drives the
// counter run/clr controls, captures lap times into a circular buffer and selects what the
// display shows: live count, the lap just taken (frozen) or a recalled lap.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   start_stop_btn raw start/stop button
//   lap_btn        raw lap/recall button
//   reset_btn      raw stopwatch-clear button
//   time_in        current count from the counter datapath
//   run            counter enable
//   clr            counter synchronous clear
//   disp_sel       0 = show time_in, 1 = show lap_out
//   lap_out        lap value to display (registered)
//   lap_idx        index of the displayed lap, 0 = oldest stored
//   lap_cnt        number of stored laps, saturates at 2**LAP_IDX_W
module stopwatch_lap_controller #(
    parameter int unsigned TIME_W      = 24,
    parameter int unsigned DEB_CYCLES  = 16,
    parameter int unsigned LAP_IDX_W   = 2,
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_stop_btn,
    input  logic                 lap_btn,
    input  logic                 reset_btn,
    input  logic [TIME_W-1:0]    time_in,
    output logic                 run,
    output logic                 clr,
    output logic                 disp_sel,
    output logic [TIME_W-1:0]    lap_out,
    output logic [LAP_IDX_W-1:0] lap_idx,
    output logic [LAP_IDX_W:0]   lap_cnt
);

    localparam int          LAP_DEPTH = 2 ** LAP_IDX_W;
    localparam int unsigned DEB_W     = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [LAP_IDX_W:0] LAP_FULL  = (LAP_IDX_W + 1)'(LAP_DEPTH);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    // ------------------------------------------------------------------
    // Button conditioning. Bit 0 = start/stop, bit 1 = lap, bit 2 = reset.
    // ------------------------------------------------------------------
    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync2_q, level_q, press_q;
    logic [DEB_W-1:0] deb_cnt_q [3];

    assign btn_raw = {reset_btn, lap_btn, start_stop_btn};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == level_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES)) begin
                    // Stable for the full window: accept the new level. Only a 0->1 change
                    // produces a press pulse.
                    level_q[i]   <= ~level_q[i];
                    deb_cnt_q[i] <= '0;
                    press_q[i]   <= ~level_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Priority: clear > start/stop > lap.
    logic rst_press, ss_press, lap_press;
    assign rst_press = press_q[2];
    assign ss_press  = press_q[0] & ~press_q[2];
    assign lap_press = press_q[1] & ~press_q[0] & ~press_q[2];

    // ------------------------------------------------------------------
    // Sequencing FSM and lap buffer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StLapHold,
        StPause,
        StRecall
    } state_e;

    state_e               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [LAP_IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LAP_IDX_W-1:0] lap_idx_q, lap_idx_d;
    logic [LAP_IDX_W:0]   lap_cnt_q, lap_cnt_d;
    logic [TIME_W-1:0]    lap_out_q, lap_out_d;
    logic [TIME_W-1:0]    lap_buf_q [LAP_DEPTH];
    logic                 run_q, clr_q, disp_sel_q;
    logic                 cap_en;

    logic                 lap_full;
    logic [LAP_IDX_W-1:0] rd_base, idx_next, rd_next;
    logic [LAP_IDX_W:0]   last_idx;

    // Once the buffer has wrapped, the oldest entry sits at wr_ptr.
    assign lap_full = (lap_cnt_q == LAP_FULL);
    assign rd_base  = lap_full ? wr_ptr_q : '0;
    assign idx_next = lap_idx_q + 1'b1;
    assign rd_next  = rd_base + idx_next;
    assign last_idx = lap_cnt_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wr_ptr_d  = wr_ptr_q;
        lap_idx_d = lap_idx_q;
        lap_cnt_d = lap_cnt_q;
        lap_out_d = lap_out_q;
        cap_en    = 1'b0;

        if (rst_press) begin
            state_d   = StIdle;
            lap_cnt_d = '0;
            wr_ptr_d  = '0;
            lap_idx_d = '0;
            lap_out_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ss_press) state_d = StRun;
                end
                StRun: begin
                    if (ss_press) begin
                        state_d = StPause;
                    end else if (lap_press) begin
                        cap_en  = 1'b1;
                        state_d = StLapHold;
                    end
                end
                StLapHold: begin
                    if (ss_press) begin
                        state_d = StPause;
                    end else if (lap_press) begin
                        cap_en = 1'b1;
                    end else if (hold_q == '0) begin
                        state_d = StRun;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                StPause: begin
                    if (ss_press) begin
                        state_d = StRun;
                    end else if (lap_press && (lap_cnt_q != '0)) begin
                        state_d   = StRecall;
                        lap_idx_d = '0;
                        lap_out_d = lap_buf_q[rd_base];
                    end
                end
                StRecall: begin
                    if (ss_press) begin
                        state_d   = StRun;
                        lap_idx_d = '0;
                    end else if (lap_press) begin
                        if ({1'b0, lap_idx_q} == last_idx) begin
                            state_d   = StPause;
                            lap_idx_d = '0;
                        end else begin
                            lap_idx_d = idx_next;
                            lap_out_d = lap_buf_q[rd_next];
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (cap_en) begin
            hold_d    = HOLD_LOAD;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            lap_cnt_d = lap_full ? lap_cnt_q : lap_cnt_q + 1'b1;
            lap_out_d = time_in;
        end
    end

    // Outputs are decoded from the next state so the registered copies always match
    // the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            lap_idx_q  <= '0;
            lap_cnt_q  <= '0;
            lap_out_q  <= '0;
            run_q      <= 1'b0;
            clr_q      <= 1'b1;
            disp_sel_q <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            lap_idx_q  <= lap_idx_d;
            lap_cnt_q  <= lap_cnt_d;
            lap_out_q  <= lap_out_d;
            run_q      <= (state_d == StRun) || (state_d == StLapHold);
            clr_q      <= (state_d == StIdle);
            disp_sel_q <= (state_d == StLapHold) || (state_d == StRecall);
            if (cap_en) begin
                lap_buf_q[wr_ptr_q] <= time_in;
            end
        end
    end

    assign run      = run_q;
    assign clr      = clr_q;
    assign disp_sel = disp_sel_q;
    assign lap_out  = lap_out_q;
    assign lap_idx  = lap_idx_q;
    assign lap_cnt  = lap_cnt_q;

endmodule

// File: doc/stopwatch_lap_controller.md
Name: stopwatch_lap_controller

Overview:
Sequencing controller for the stopwatch counter datapath. It conditions three raw push-buttons (start/stop, lap, reset) and drives the counter's run/clr controls. It also captures lap times from the counter into a small circular buffer and selects the display source: live count, frozen lap, or recalled lap. It sits between the board buttons and the time counter/display mux.

Parameters:
TIME_W, 24, width of the counter time bus.
DEB_CYCLES, 16, debounce stability window in clk cycles (>=2).
LAP_IDX_W, 2, lap index width; LAP_DEPTH = 2**LAP_IDX_W entries.
HOLD_CYCLES, 1000, lap-freeze display duration in clk cycles (>=2).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset (0 = reset).
start_stop_btn  in  1  raw, asynchronous start/stop button.
lap_btn  in  1  raw lap/recall button.
reset_btn  in  1  raw stopwatch-clear button.
time_in  in  TIME_W  current count from the counter datapath.
run  out  1  counter enable.
clr  out  1  counter synchronous clear.
disp_sel  out  1  0 = live time_in, 1 = lap_out.
lap_out  out  TIME_W  lap value to display (registered).
lap_idx  out  LAP_IDX_W  index of the displayed lap, 0 = oldest stored.
lap_cnt  out  LAP_IDX_W+1  number of stored laps, saturates at LAP_DEPTH.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; run=0, clr=1, disp_sel=0.
  - lap_out=0, lap_idx=0, lap_cnt=0.
  - wr_ptr=0, hold timer=0, buffer entries=0, debouncers cleared (level 0).
- Button conditioning, identical for each button:
  - 2-flop synchronizer.
  - Debounce counter counts consecutive cycles where the synced value differs from the debounced level; it clears when they are equal.
  - The debounced level toggles once the count reaches DEB_CYCLES.
  - Press = registered one-cycle pulse on the debounced rising edge.
  - Latency from the first clk edge sampling raw=1 to the press pulse is exactly DEB_CYCLES+3 edges.
  - Glitches shorter than DEB_CYCLES produce no pulse.
  - Release generates no pulse.
- Priority within a cycle: reset press > start/stop press > lap press. Lower-priority presses in the same cycle are dropped.
- Outputs are Moore-decoded from the state register:
  - run=1 in RUN and LAP_HOLD.
  - clr=1 only in IDLE.
  - disp_sel=1 in LAP_HOLD and RECALL.
- FSM states: IDLE, RUN, LAP_HOLD, PAUSE, RECALL.
  - IDLE: ss press -> RUN. Lap press ignored.
  - RUN: ss press -> PAUSE. Lap press -> capture time_in, load hold timer = HOLD_CYCLES-1, -> LAP_HOLD.
  - LAP_HOLD: lap_out = latest capture. Timer decrements each cycle; at 0 -> RUN. Lap press -> new capture, timer reloaded, stay. Ss press -> PAUSE.
  - PAUSE: ss press -> RUN. Lap press with lap_cnt>0 -> RECALL, lap_idx=0. Lap press with lap_cnt=0 is ignored.
  - RECALL: lap_out = buffer entry lap_idx (oldest-first). Lap press -> lap_idx+1; at lap_idx = lap_cnt-1, lap press -> PAUSE and lap_idx=0. Ss press -> RUN.
  - Any state: reset press -> IDLE, lap_cnt=0, wr_ptr=0, lap_idx=0, lap_out=0. Buffer contents need not be cleared.
- Capture:
  - Samples time_in in the cycle the lap press is seen.
  - Writes buffer[wr_ptr], wr_ptr+1 mod LAP_DEPTH, lap_cnt+1 saturating at LAP_DEPTH.
  - lap_out updates on the following edge.
- Buffer full: the oldest entry is overwritten. Recall order stays oldest-first; physical read address = (wr_ptr + lap_idx) mod LAP_DEPTH when full, else lap_idx.
- Hold timer counts in LAP_HOLD only. Leaving LAP_HOLD abandons it.

Test Plan:
- Debounce: 5-cycle glitch on start_stop_btn -> no press; 40-cycle hold (DEB_CYCLES=16) -> run rises exactly 20 edges after the first sample of 1; clr falls the same cycle.
- Run/pause: ss press, ss press, ss press -> state sequence IDLE->RUN->PAUSE->RUN; run=1,0,1; clr stays 0.
- Lap hold: in RUN with time_in=0x000123, lap press -> lap_out=0x000123, disp_sel=1 for exactly HOLD_CYCLES cycles, then disp_sel=0, run=1 throughout.
- Overflow/recall: 6 laps with time_in=10,20,...,60 (DEPTH 4) -> lap_cnt=4; pause, then 4 lap presses -> lap_out 30,40,50,60 with lap_idx 0..3; 5th press -> PAUSE, disp_sel=0.
- Simultaneous: ss and lap presses in the same cycle while in RUN -> PAUSE, no capture, lap_cnt unchanged.
- Clear/async reset: reset press during RECALL -> IDLE, clr=1, lap_cnt=0; reset=0 mid-LAP_HOLD -> all outputs at reset values immediately, without a clock edge.
